batch_packetizer: RTL and testbench

BATCH_PACKETIZER -- requirements
Module: batch_packetizer

---
 rtl/batch_packetizer.sv | 127 ++++++++++++
 tb/tb_batch_packetizer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/batch_packetizer.sv
// -----------------------------------------------------------------------------
// batch_packetizer
//
// Frames a stream of 512-bit result lines into batches. The first line of a
// batch carries the element count N in bits [511:480]. The batch spans
// L = ceil((N+1)/16) lines, and TLAST marks line L. A single registered output
// stage gives one cycle of latency and full one-line-per-clock throughput.
//
// Optional feature, macro BATCH_PACKETIZER_TKEEP_EN:
//   defined   - TKEEP on the final line enables only the 4*W valid bytes, where
//               W = (N+1) mod 16, or 16 when that is 0.
//   undefined - TKEEP is all-ones on every valid line.
// -----------------------------------------------------------------------------
module batch_packetizer #(
   parameter int BATCH_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            cfg_N,
   input  logic                   in_data_TVALID,
   output logic                   in_data_TREADY,
   input  logic [511:0]           in_data_TDATA,
   output logic                   tx_data_TVALID,
   input  logic                   tx_data_TREADY,
   output logic [511:0]           tx_data_TDATA,
   output logic [63:0]            tx_data_TKEEP,
   output logic                   tx_data_TLAST,
   output logic                   busy,
   output logic [BATCH_CNT_W-1:0] batch_cnt
);

   typedef enum logic {
      IDLE = 1'b0,
      BODY = 1'b1
   } state_t;

   state_t      state;
   // NOTE: 33 bits so that N = 0xFFFFFFFF cannot overflow when computing N+16.
   logic [32:0] rem_lines;
   logic [32:0] first_lines;
   logic        in_acc;
   logic [63:0] keep_last;

   // Line count of a batch that would start on this cycle.
   assign first_lines = ({1'b0, cfg_N} + 33'd16) >> 4;

   // NOTE: ready depends only on the output register and downstream ready,
   // never on in_data_TVALID, so there is no combinational valid-to-ready loop.
   assign in_data_TREADY = !rst && (!tx_data_TVALID || tx_data_TREADY);
   assign in_acc         = in_data_TVALID && in_data_TREADY;

`ifdef BATCH_PACKETIZER_TKEEP_EN
   logic [3:0] n_lo;

   // Byte enables for the final line: 4*(n_low+1) bytes, covering 4..64.
   function automatic logic [63:0] last_keep(input logic [3:0] n_low);
      logic [6:0] n_bytes;
      n_bytes = {1'b0, n_low, 2'b00} + 7'd4;
      for (int i = 0; i < 64; i++) begin
         last_keep[i] = (7'(i) < n_bytes);
      end
   endfunction

   // Remember N mod 16 of the batch in flight for the final line's TKEEP.
   always_ff @(posedge clk) begin
      if (rst) begin
         n_lo <= 4'd0;
      end else if (in_acc && state == IDLE) begin
         n_lo <= cfg_N[3:0];
      end
   end

   // A single-line batch takes its width from cfg_N directly.
   assign keep_last = last_keep((state == IDLE) ? cfg_N[3:0] : n_lo);
`else
   assign keep_last = '1;
`endif

   // Batch FSM and output stage: loads a line on input accept, drops valid
   // once the downstream takes it, and holds everything while stalled.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register here sees the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         rem_lines      <= '0;
         busy           <= 1'b0;
         batch_cnt      <= '0;
         tx_data_TVALID <= 1'b0;
         tx_data_TLAST  <= 1'b0;
         tx_data_TDATA  <= '0;
         tx_data_TKEEP  <= '0;
      end else if (in_acc) begin
         tx_data_TVALID <= 1'b1;
         if (state == IDLE) begin
            tx_data_TDATA <= {cfg_N, in_data_TDATA[479:0]};
            if (first_lines == 33'd1) begin
               tx_data_TLAST <= 1'b1;
               tx_data_TKEEP <= keep_last;
               batch_cnt     <= batch_cnt + BATCH_CNT_W'(1);
            end else begin
               tx_data_TLAST <= 1'b0;
               tx_data_TKEEP <= '1;
               rem_lines     <= first_lines - 33'd1;
               state         <= BODY;
               busy          <= 1'b1;
            end
         end else begin
            tx_data_TDATA <= in_data_TDATA;
            rem_lines     <= rem_lines - 33'd1;
            if (rem_lines == 33'd1) begin
               tx_data_TLAST <= 1'b1;
               tx_data_TKEEP <= keep_last;
               batch_cnt     <= batch_cnt + BATCH_CNT_W'(1);
               state         <= IDLE;
               busy          <= 1'b0;
            end else begin
               tx_data_TLAST <= 1'b0;
               tx_data_TKEEP <= '1;
            end
         end
      end else if (tx_data_TREADY) begin
         tx_data_TVALID <= 1'b0;
      end
   end

endmodule

// File: tb/tb_batch_packetizer.sv
// -----------------------------------------------------------------------------
// tb_batch_packetizer
//
// Directed scenarios plus randomized batches. A driver feeds lines and pushes
// the expected framed line into a queue for every accepted input. A monitor
// pops and compares on every output handshake, and also checks that a stalled
// output holds still. Expected lines come from N alone:
// L = ceil((N+1)/16), a header on line 0, and TLAST on line L-1.
// -----------------------------------------------------------------------------
module tb_batch_packetizer;

   typedef struct {
      logic [511:0] data;
      logic [63:0]  keep;
      logic         last;
   } line_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  cfg_N = '0;
   logic         in_data_TVALID = 1'b0;
   logic         in_data_TREADY;
   logic [511:0] in_data_TDATA = '0;
   logic         tx_data_TVALID;
   logic         tx_data_TREADY = 1'b1;
   logic [511:0] tx_data_TDATA;
   logic [63:0]  tx_data_TKEEP;
   logic         tx_data_TLAST;
   logic         busy;
   logic [15:0]  batch_cnt;

   int     tests_run    = 0;
   int     tests_failed = 0;
   int     exp_batches  = 0;
   longint cyc          = 0;
   bit     ready_rand   = 1'b0;
   bit     ready_fixed  = 1'b1;
   line_t  exp_q[$];
   longint hs_cyc[$];

   batch_packetizer #(.BATCH_CNT_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .cfg_N          (cfg_N),
      .in_data_TVALID (in_data_TVALID),
      .in_data_TREADY (in_data_TREADY),
      .in_data_TDATA  (in_data_TDATA),
      .tx_data_TVALID (tx_data_TVALID),
      .tx_data_TREADY (tx_data_TREADY),
      .tx_data_TDATA  (tx_data_TDATA),
      .tx_data_TKEEP  (tx_data_TKEEP),
      .tx_data_TLAST  (tx_data_TLAST),
      .busy           (busy),
      .batch_cnt      (batch_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ready: fixed level or random, changed on the falling edge.
   always @(negedge clk) begin
      tx_data_TREADY = ready_rand ? ($urandom_range(0, 3) != 0) : ready_fixed;
   end

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference line count in 64-bit arithmetic.
   function automatic longint lines_of(input logic [31:0] n);
      longint nn;
      nn = {32'd0, n};
      return (nn + 1 + 15) / 16;
   endfunction

   function automatic logic [63:0] model_keep(input logic [31:0] n, input bit last);
`ifdef BATCH_PACKETIZER_TKEEP_EN
      longint w;
      if (!last) return '1;
      w = ({32'd0, n} + 1) % 16;
      if (w == 0) w = 16;
      if (w == 16) return '1;
      return (64'd1 << (4 * w)) - 64'd1;
`else
      return '1;
`endif
   endfunction

   // Drives one line and waits for the accept. Valid is dropped just after the
   // accepting edge; the next call raises it again before the following edge.
   task automatic send_line(input logic [511:0] d, input logic [31:0] n, output bit ok);
      int waited;
      waited = 0;
      ok = 1'b1;
      @(negedge clk);
      in_data_TVALID = 1'b1;
      in_data_TDATA  = d;
      cfg_N          = n;
      #1;
      while (!in_data_TREADY) begin
         waited++;
         if (waited > 1000) begin
            check("accept_timeout", 0, 1);
            in_data_TVALID = 1'b0;
            ok = 1'b0;
            return;
         end
         @(negedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      in_data_TVALID = 1'b0;
   endtask

   // Sends line idx of a batch of size n and records the expected output.
   task automatic send_model_line(input logic [31:0] n, input longint idx);
      logic [511:0] d;
      line_t        e;
      longint       lines;
      bit           ok;
      lines = lines_of(n);
      for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
      send_line(d, (idx == 0) ? n : $urandom(), ok);
      if (ok) begin
         e.data = (idx == 0) ? {n, d[479:0]} : d;
         e.last = (idx == lines - 1);
         e.keep = model_keep(n, e.last);
         exp_q.push_back(e);
         if (e.last) exp_batches++;
      end
   endtask

   task automatic send_batch(input logic [31:0] n, input longint max_lines, input bit gaps);
      longint lines;
      lines = lines_of(n);
      for (longint i = 0; i < lines && i < max_lines; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               @(negedge clk);
               cfg_N = $urandom();
            end
         end
         send_model_line(n, i);
      end
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      @(negedge clk);
      #3;
      while ((exp_q.size() != 0 || tx_data_TVALID) && t < 1000) begin
         @(negedge clk);
         #3;
         t++;
      end
      check(name, exp_q.size(), 0);
   endtask

   // Asserts reset for two edges, checking outputs after the first one.
   task automatic apply_reset(input string name);
      @(negedge clk);
      rst = 1'b1;
      in_data_TVALID = 1'b0;
      #1;
      exp_q.delete();
      exp_batches = 0;
      @(negedge clk);
      #2;
      check({name, "_tvalid"}, tx_data_TVALID, 0);
      check({name, "_busy"}, busy, 0);
      check({name, "_cnt"}, batch_cnt, 0);
      check({name, "_tlast"}, tx_data_TLAST, 0);
      check({name, "_tkeep"}, tx_data_TKEEP, 0);
      check({name, "_tdata"}, tx_data_TDATA, 0);
      check({name, "_in_ready"}, in_data_TREADY, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: compares every output handshake and checks stalled lines hold.
   initial begin
      line_t        e;
      bit           held;
      logic [511:0] h_data;
      logic [63:0]  h_keep;
      logic         h_last;
      held = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            held = 1'b0;
         end else begin
            if (held) begin
               check("hold_valid", tx_data_TVALID, 1);
               check("hold_data", tx_data_TDATA, h_data);
               check("hold_keep", tx_data_TKEEP, h_keep);
               check("hold_last", tx_data_TLAST, h_last);
            end
            if (tx_data_TVALID && tx_data_TREADY) begin
               held = 1'b0;
               hs_cyc.push_back(cyc);
               if (exp_q.size() == 0) begin
                  check("spurious_line", exp_q.size(), 1);
               end else begin
                  e = exp_q.pop_front();
                  check("out_data", tx_data_TDATA, e.data);
                  check("out_keep", tx_data_TKEEP, e.keep);
                  check("out_last", tx_data_TLAST, e.last);
               end
            end else if (tx_data_TVALID) begin
               held   = 1'b1;
               h_data = tx_data_TDATA;
               h_keep = tx_data_TKEEP;
               h_last = tx_data_TLAST;
            end else begin
               held = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      longint l;

      // Reset state.
      apply_reset("reset");

      // Single-line batch.
      send_batch(32'd0, 100, 1'b0);
      @(negedge clk);
      #3;
      check("single_busy", busy, 0);
      drain("single_drain");
      check("single_cnt", batch_cnt, 16'(exp_batches));

      // Three-line batch; busy while it is partially sent.
      send_model_line(32'd40, 0);
      @(negedge clk);
      #3;
      check("multi_busy_mid", busy, 1);
      send_model_line(32'd40, 1);
      send_model_line(32'd40, 2);
      drain("multi_drain");
      check("multi_busy_end", busy, 0);
      check("multi_cnt", batch_cnt, 16'(exp_batches));

      // Backpressure during line 2 of a two-line batch.
      send_model_line(32'd31, 0);
      drain("bp_first_drain");
      ready_fixed = 1'b0;
      send_model_line(32'd31, 1);
      repeat (5) begin
         @(negedge clk);
         #3;
         check("bp_tvalid", tx_data_TVALID, 1);
         check("bp_in_ready", in_data_TREADY, 0);
      end
      ready_fixed = 1'b1;
      drain("bp_drain");
      check("bp_cnt", batch_cnt, 16'(exp_batches));

      // Back-to-back batches: a two-line batch then a one-line batch.
      hs_cyc.delete();
      send_batch(32'd16, 100, 1'b0);
      send_batch(32'd0, 100, 1'b0);
      drain("b2b_drain");
      check("b2b_lines", hs_cyc.size(), 3);
      if (hs_cyc.size() == 3) check("b2b_no_gap", hs_cyc[2] - hs_cyc[0], 2);
      check("b2b_cnt", batch_cnt, 16'(exp_batches));

      // Reset in the middle of a seven-line batch, then a clean batch.
      send_batch(32'd100, 3, 1'b0);
      apply_reset("midrst");
      send_batch(32'd0, 100, 1'b0);
      drain("post_rst_drain");
      check("post_rst_cnt", batch_cnt, 1);

      // Largest N: the line count must not overflow.
      l = lines_of(32'hFFFF_FFFF);
      send_batch(32'hFFFF_FFFF, 2, 1'b0);
      @(negedge clk);
      #3;
      check("ovf_rem_lines", dut.rem_lines, 33'(l - 2));
      check("ovf_busy", busy, 1);
      drain("ovf_drain");
      apply_reset("ovf_rst");

      // Randomized batches with random gaps and downstream ready.
      ready_rand = 1'b1;
      for (int b = 0; b < 25; b++) begin
         send_batch($urandom_range(0, 120), 100, 1'b1);
      end
      drain("rand_drain");
      check("rand_cnt", batch_cnt, 16'(exp_batches));
      check("rand_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
